// File: rtl/status_pio_pkg.sv
// status_pio_pkg: register map constants and edge-mode encoding for status_pio_mc.
// Optional feature macro: STATUS_PIO_SYNC_EN (2-flop synchronizer on every status bit).
package status_pio_pkg;

    localparam int unsigned REG_DATA      = 0;
    localparam int unsigned REG_SNAP      = 1;
    localparam int unsigned REG_EDGE      = 2;
    localparam int unsigned REG_MASK      = 3;
    localparam int unsigned REGS_PER_CH   = 4;
    localparam int unsigned REG_SEL_W     = $clog2(REGS_PER_CH);
    localparam int unsigned CTRL_SNAP_BIT = 0;
    localparam int unsigned BUS_W         = 32;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

`ifdef STATUS_PIO_SYNC_EN
    localparam int unsigned SYNC_STAGES = 2;
`else
    localparam int unsigned SYNC_STAGES = 0;
`endif

    // Edge detection stays gated until cur/prev both hold real post-reset samples.
    localparam int unsigned ARM_DEPTH = SYNC_STAGES + 1;

endpackage

// File: rtl/status_pio_chan.sv
// status_pio_chan: one status channel -- optional synchronizer, cur/prev sampling,
// edge capture with W1C, interrupt mask and snapshot register.
// Optional feature macro: STATUS_PIO_SYNC_EN.
module status_pio_chan
    import status_pio_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EDGE_MODE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] status_i,
    input  logic             armed_i,
    input  logic             snap_i,
    input  logic             edge_we_i,
    input  logic             mask_we_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] data_o,
    output logic [WIDTH-1:0] snap_o,
    output logic [WIDTH-1:0] edge_o,
    output logic [WIDTH-1:0] mask_o,
    output logic             hit_c_o
);

    localparam edge_mode_e MODE = edge_mode_e'(2'(EDGE_MODE));

    logic [WIDTH-1:0] sample;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] cur_q,  cur_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] snap_q, snap_d;

`ifdef STATUS_PIO_SYNC_EN
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Two-flop synchronizer for asynchronous status sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= status_i;
            sync2_q <= sync1_q;
        end
    end

    assign sample = sync2_q;
`else
    assign sample = status_i;
`endif

    // Event selection for the configured edge mode.
    always_comb begin
        ev = '0;
        case (MODE)
            EDGE_RISE: ev = cur_q & ~prev_q;
            EDGE_FALL: ev = ~cur_q & prev_q;
            default:   ev = cur_q ^ prev_q;
        endcase
    end

    // Next-state: prev is preloaded with the incoming sample while unarmed so the
    // first armed comparison never sees the reset value; new events beat W1C.
    always_comb begin
        cur_d  = sample;
        prev_d = armed_i ? cur_q : sample;
        edge_d = (edge_q & ~(edge_we_i ? wdata_i : '0)) | (ev & {WIDTH{armed_i}});
        mask_d = mask_we_i ? wdata_i : mask_q;
        snap_d = snap_i ? cur_q : snap_q;
    end

    // Channel state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_q  <= '0;
            prev_q <= '0;
            edge_q <= '0;
            mask_q <= '0;
            snap_q <= '0;
        end else begin
            cur_q  <= cur_d;
            prev_q <= prev_d;
            edge_q <= edge_d;
            mask_q <= mask_d;
            snap_q <= snap_d;
        end
    end

    assign data_o  = cur_q;
    assign snap_o  = snap_q;
    assign edge_o  = edge_q;
    assign mask_o  = mask_q;
    assign hit_c_o = |(edge_q & mask_q);

endmodule

// File: rtl/status_pio_mc.sv
// status_pio_mc: multi-channel status PIO behind an Avalon-MM slave (read latency 1)
// with a single level interrupt. Optional feature macro: STATUS_PIO_SYNC_EN.
module status_pio_mc
    import status_pio_pkg::*;
#(
    parameter int unsigned CHANNELS  = 4,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned EDGE_MODE = 2,
    parameter int unsigned ADDR_W    = $clog2(CHANNELS * REGS_PER_CH + 1)
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic [CHANNELS*WIDTH-1:0] status_in,
    input  logic [ADDR_W-1:0]         avs_address,
    input  logic                      avs_read,
    input  logic                      avs_write,
    input  logic [BUS_W-1:0]          avs_writedata,
    output logic [BUS_W-1:0]          avs_readdata,
    output logic                      avs_readdatavalid,
    output logic                      irq
);

    localparam int unsigned CTRL_ADDR = CHANNELS * REGS_PER_CH;
    localparam int unsigned SEL_W     = ADDR_W - REG_SEL_W;

    logic [REG_SEL_W-1:0] reg_sel;
    logic [SEL_W-1:0]     ch_sel;
    logic                 in_chan_space;
    logic                 wr_chan;
    logic                 snap_all;

    logic [WIDTH-1:0]     data_w [CHANNELS];
    logic [WIDTH-1:0]     snap_w [CHANNELS];
    logic [WIDTH-1:0]     edge_w [CHANNELS];
    logic [WIDTH-1:0]     mask_w [CHANNELS];
    logic [CHANNELS-1:0]  hit_w;
    logic [CHANNELS-1:0]  edge_we;
    logic [CHANNELS-1:0]  mask_we;

    logic [BUS_W-1:0]     rdata_c;
    logic [BUS_W-1:0]     rdata_q, rdata_d;
    logic                 rvalid_q, rvalid_d;
    logic                 irq_q, irq_d;
    logic [ARM_DEPTH-1:0] arm_q, arm_d;
    logic                 armed;

    assign reg_sel       = avs_address[REG_SEL_W-1:0];
    assign ch_sel        = avs_address[ADDR_W-1:REG_SEL_W];
    assign in_chan_space = avs_address < ADDR_W'(CTRL_ADDR);
    assign wr_chan       = avs_write && in_chan_space;
    assign snap_all      = avs_write && (avs_address == ADDR_W'(CTRL_ADDR))
                           && avs_writedata[CTRL_SNAP_BIT];
    assign armed         = arm_q[ARM_DEPTH-1];

    // Per-channel datapath and write strobes.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign edge_we[c] = wr_chan && (ch_sel == SEL_W'(c)) && (reg_sel == REG_SEL_W'(REG_EDGE));
        assign mask_we[c] = wr_chan && (ch_sel == SEL_W'(c)) && (reg_sel == REG_SEL_W'(REG_MASK));

        status_pio_chan #(
            .WIDTH     (WIDTH),
            .EDGE_MODE (EDGE_MODE)
        ) u_chan (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .status_i  (status_in[c*WIDTH +: WIDTH]),
            .armed_i   (armed),
            .snap_i    (snap_all),
            .edge_we_i (edge_we[c]),
            .mask_we_i (mask_we[c]),
            .wdata_i   (avs_writedata[WIDTH-1:0]),
            .data_o    (data_w[c]),
            .snap_o    (snap_w[c]),
            .edge_o    (edge_w[c]),
            .mask_o    (mask_w[c]),
            .hit_c_o   (hit_w[c])
        );
    end

    // Read mux; CTRL and unmapped addresses return 0.
    always_comb begin
        rdata_c = '0;
        if (in_chan_space) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_sel == SEL_W'(c)) begin
                    case (reg_sel)
                        REG_SEL_W'(REG_DATA): rdata_c = BUS_W'(data_w[c]);
                        REG_SEL_W'(REG_SNAP): rdata_c = BUS_W'(snap_w[c]);
                        REG_SEL_W'(REG_EDGE): rdata_c = BUS_W'(edge_w[c]);
                        REG_SEL_W'(REG_MASK): rdata_c = BUS_W'(mask_w[c]);
                        default:              rdata_c = '0;
                    endcase
                end
            end
        end
    end

    // Next-state for read response, interrupt and arming shift register.
    always_comb begin
        rvalid_d = avs_read;
        rdata_d  = avs_read ? rdata_c : '0;
        irq_d    = |hit_w;
        arm_d    = (arm_q << 1) | ARM_DEPTH'(1);
    end

    // Top-level registers; a pending read response is dropped by reset.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            irq_q    <= 1'b0;
            arm_q    <= '0;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            irq_q    <= irq_d;
            arm_q    <= arm_d;
        end
    end

    assign avs_readdata      = rdata_q;
    assign avs_readdatavalid = rvalid_q;
    assign irq               = irq_q;

endmodule

// File: doc/status_pio_mc.md
Name: status_pio_mc

Overview:
- Multi-channel, parametrised successor to the single 32-bit status PIO on the HPS lightweight bridge.
- Samples CHANNELS independent WIDTH-bit status buses from the accelerator fabric.
- Per channel: level register, atomic snapshot register, edge-capture register and interrupt mask.
- Exposes all of these through an Avalon-MM slave with fixed read latency 1, and drives one level interrupt to the HPS.

Parameters:
- CHANNELS, 4, number of status channels (1..16).
- WIDTH, 32, bits per channel (1..32); upper readdata bits read 0.
- EDGE_MODE, 2, edge-capture event: 0 rising, 1 falling, 2 any change.
- ADDR_W, $clog2(CHANNELS*4+1), word address width (derived; not overridden).

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  reset, asynchronous assert, active-low.
- status_in  in  CHANNELS*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data.
- avs_readdatavalid  out  1  read data qualifier.
- irq  out  1  level interrupt, active-high.

Behaviour:
- Reset: all outputs 0, all internal registers 0, armed=0.
- Register map, channel c, word address c*4+r:
  - r0 DATA: RO, current sample.
  - r1 SNAP: RO, snapshot.
  - r2 EDGE: W1C.
  - r3 MASK: RW.
- Address CHANNELS*4 is CTRL:
  - Write bit0=1 snapshots every channel's DATA into SNAP in the same cycle (atomic).
  - CTRL reads 0.
- Unmapped addresses read 0; writes to them are ignored.
- Sampling path:
  - cur <= input (after the optional synchronizer); prev <= cur.
  - DATA = cur; latency 1 cycle without the synchronizer.
- Edge detect:
  - ev = cur&~prev (mode 0), ~cur&prev (mode 1), cur^prev (mode 2).
  - EDGE <= (EDGE & ~clr) | (ev & {WIDTH{armed}}).
  - armed sets on the first clock after reset release. This suppresses spurious edges from the 0 reset value of prev.
- Simultaneous new edge and W1C on the same bit: set wins and the bit stays 1.
- irq <= OR over channels of |(EDGE & MASK); registered, 1 cycle after EDGE or MASK changes.
- Reads:
  - avs_readdatavalid asserts exactly 1 cycle after avs_read; avs_readdata is held at 0 when not valid.
  - Back-to-back reads are accepted every cycle.
- Simultaneous read and write to the same address: read returns the pre-write value.
- Snapshot trigger and W1C in the same write are impossible (different addresses).
- Reset asserted mid-transaction: a pending readdatavalid is dropped; all state returns to reset values asynchronously.

Optional Feature:
- Macro STATUS_PIO_SYNC_EN.
- Defined: each status_in bit passes through a 2-flop synchronizer before cur. DATA latency becomes 3 cycles; EDGE sets at 4 cycles; irq asserts at 5 cycles.
- Undefined: status_in is registered directly into cur, for synchronous sources only. DATA at 1 cycle, EDGE at 2 cycles, irq at 3 cycles.

Decomposition:
- Package status_pio_pkg holds: register offset constants (REG_DATA=0, REG_SNAP=1, REG_EDGE=2, REG_MASK=3, REGS_PER_CH=4); edge-mode enum; CTRL_SNAP_BIT=0.
- One sub-module, status_pio_chan, per channel: synchronizer, cur/prev, edge logic, EDGE/MASK/SNAP registers.
- Top level holds: address decode, read mux, irq OR, armed flop.

Test Plan:
- Reset, then read every address -> all return 0; readdatavalid pulses exactly 1 cycle after each read; irq=0.
- CHANNELS=4, EDGE_MODE=0: drive ch1 from 0x0 to 0x00000005 -> DATA1=0x5 at the specified latency; EDGE1=0x5 one cycle later; irq stays 0 (MASK=0).
- Write MASK1=0x4 -> irq=1 one cycle later. Write EDGE1=0x4 -> irq=0. EDGE1 reads 0x1.
- W1C of EDGE0 bit3 in the same cycle a new rising edge occurs on ch0 bit3 -> EDGE0 bit3 reads 1.
- Set ch0=0xA5, ch3=0x3C, write CTRL=1, then change the inputs -> SNAP0=0xA5 and SNAP3=0x3C, both unchanged afterwards.
- status_in all 1s held through reset release -> EDGE stays 0 (armed suppression). Reset asserted during a read -> readdatavalid never asserts.
